// File: rtl/csa_word_sequencer.sv
// Byte-serial add/subtract sequencer built around one 8-bit
// conditional-sum adder that is reused for every byte slice.

module conditional_sum_adder (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] correctSum,
  output logic       cout
);

  logic [7:0] s0, s1;
  logic [7:0] k0, k1;
  logic       lo0, lo1, h0, h1, nc0, nc1;

  // Build sum/carry pairs for cin=0/1 per bit, then merge blocks 1->2->4->8.
  always_comb begin
    s0  = x ^ y;
    s1  = ~(x ^ y);
    k0  = x & y;
    k1  = x | y;
    lo0 = 1'b0;
    lo1 = 1'b0;
    h0  = 1'b0;
    h1  = 1'b0;
    nc0 = 1'b0;
    nc1 = 1'b0;
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < 8; j += (2 << l)) begin
        lo0 = k0[j];
        lo1 = k1[j];
        for (int b = j + (1 << l); b < j + (2 << l); b++) begin
          h0    = s0[b];
          h1    = s1[b];
          s0[b] = lo0 ? h1 : h0;
          s1[b] = lo1 ? h1 : h0;
        end
        nc0   = lo0 ? k1[j + (1 << l)] : k0[j + (1 << l)];
        nc1   = lo1 ? k1[j + (1 << l)] : k0[j + (1 << l)];
        k0[j] = nc0;
        k1[j] = nc1;
      end
    end
    correctSum = cin ? s1 : s0;
    cout       = cin ? k1[0] : k0[0];
  end

endmodule

module csa_word_sequencer #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] a,
  input  logic [8*NUM_BYTES-1:0] b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_BYTES-1:0][7:0] a_q, b_q, res_q;
  logic [IW-1:0]             idx_q;
  logic                      carry_q;
  logic                      cout_q;
  logic                      ovf_q;

  logic [7:0] add_x, add_y, add_sum;
  logic       add_co;
  logic       last;
  logic       accept;

  assign last   = (idx_q == IW'(NUM_BYTES - 1));
  assign accept = in_valid && (state_q == IDLE);
  assign add_x  = a_q[idx_q];
  assign add_y  = b_q[idx_q];

  conditional_sum_adder u_csa (
    .x          (add_x),
    .y          (add_y),
    .cin        (carry_q),
    .correctSum (add_sum),
    .cout       (add_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and one byte slice per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b ^ {W{sub}};
      idx_q   <= '0;
      carry_q <= sub;
    end else if (state_q == RUN) begin
      res_q[idx_q] <= add_sum;
      carry_q      <= add_co;
      if (last) begin
        cout_q <= add_co;
        ovf_q  <= (a_q[NUM_BYTES-1][7] == b_q[NUM_BYTES-1][7]) &&
                  (add_sum[7] != a_q[NUM_BYTES-1][7]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
